// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits,
// overlapping/non-overlapping modes, a registered match pulse and a saturating hit counter.
module pattern_seq_detector #(
    parameter int                 MAX_LEN       = 8,
    parameter int                 CNT_W         = 16,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0010_1010),
    parameter int                 RESET_LEN     = 6,
    localparam int                LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    // in_valid qualifies x with no back-pressure: a bit is consumed on every
    // rising edge where in_valid=1 (unless cfg_load or cfg_err blocks it).

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] h_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;
    logic               len_legal;

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        count_d   = count_q;
        cfg_err_d = cfg_err_q;

        h_next    = {hist_q[MAX_LEN-2:0], x};
        fill_inc  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        // For len == MAX_LEN the shift wraps to zero and the subtraction yields all ones.
        len_mask  = ({{(MAX_LEN-1){1'b0}}, 1'b1} << len_q) - {{(MAX_LEN-1){1'b0}}, 1'b1};
        hit       = (fill_inc == len_q) && (((h_next ^ pattern_q) & len_mask) == '0);
        len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            cfg_err_d = !len_legal;
        end else if (in_valid && !cfg_err_q) begin
            hist_d  = h_next;
            fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
            match_d = hit;
        end

        if (clr_count) begin
            count_d = '0;
        end else if (match_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= RESET_PATTERN;
            len_q     <= LEN_W'(RESET_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench for pattern_seq_detector: the driver pushes the hand-computed response
// of each cycle into a queue and a monitor pops and compares it after the edge.
module tb_pattern_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    pattern_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .match(match), .match_count(match_count), .cfg_err(cfg_err)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // scoreboard: {cfg_err, match_count, match}
    logic [CNT_W+1:0] exp_q[$];
    int               checks = 0;
    int               passed = 0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic             m_err  = 1'b0;
    int               step_no = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s (step %0d): got %0d expected %0d", name, step_no, act, exp);
    endtask

    always @(posedge clk) begin
        logic [CNT_W+1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_no++;
            check("match",       int'(match),       int'(e[0]));
            check("match_count", int'(match_count), int'(e[CNT_W:1]));
            check("cfg_err",     int'(cfg_err),     int'(e[CNT_W+1]));
        end
    end

    // driver tasks: one call = one clock edge with its expected match bit
    task automatic step(input logic rst, input logic v, input logic xb, input logic ld,
                        input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic clr, input logic exp_m);
        logic m;
        reset = rst; in_valid = v; x = xb; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; clr_count = clr;
        m = exp_m & ~rst;
        if (rst) begin
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            if (ld) m_err = (len == 4'd0) || (len > 4'd8);
            if (clr) m_cnt = '0;
            else if (m && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
        exp_q.push_back({m_err, m_cnt, m});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] hits);
        for (int i = n - 1; i >= 0; i--)
            step(1'b0, 1'b1, bits[i], 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, hits[i]);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        step(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;

        // reset defaults, overlapping 101010
        do_reset();
        do_reset();
        feed(32'b1010_1010_1010, 12, 32'b0000_0101_0101);

        // non-overlapping with two bubbles after bit 3
        load(8'h2A, 4'd6, 1'b0);
        feed(32'b101, 3, 32'b0);
        bubble();
        bubble();
        feed(32'b010101010, 9, 32'b001000001);

        // short pattern; load cycle carries a valid 1 that must be ignored
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 4'd3, 1'b1, 1'b0, 1'b0);
        feed(32'b11111, 5, 32'b00111);
        load(8'h07, 4'd3, 1'b0);
        feed(32'b11111, 5, 32'b00100);

        // illegal lengths, then recovery
        load(8'h2A, 4'd0, 1'b1);
        feed(32'b101010111, 9, 32'b0);
        load(8'hFF, 4'd9, 1'b1);
        feed(32'hFF, 8, 32'b0);
        load(8'h09, 4'd4, 1'b1);
        feed(32'b1001, 4, 32'b0001);

        // counter saturation and clear-on-hit
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        load(8'h01, 4'd1, 1'b1);
        feed(32'h1FFFF, 17, 32'h1FFFF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        feed(32'b101, 3, 32'b101);

        // reset mid-sequence
        do_reset();
        feed(32'b10101, 5, 32'b0);
        do_reset();
        feed(32'b0, 1, 32'b0);
        feed(32'b101010, 6, 32'b000001);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d entries left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
